matrix_fetch_streamer: RTL

Initiator and consumer on the random-matrix update handshake. On `start` it raises the generator's update request, waits for completion, and snapshots the 25-element flat matrix. It then streams the valid `row`×`col` elements in row-major order over a valid/ready interface toward the display/UART datapath.

---
 rtl/matrix_fetch_streamer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/matrix_fetch_streamer.sv
// Requests a matrix update from the generator, snapshots the 25-element result and
// streams the requested row x col window in row-major order. Optional: MATRIX_FETCH_TIMEOUT_EN.
module matrix_fetch_streamer #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_DIM        = 5
`ifdef MATRIX_FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           row,
  input  logic [2:0]           col,
  output logic                 gen_update_en,
  input  logic                 gen_update_done,
  input  logic [25*WIDTH-1:0]  gen_matrix_flat,
  output logic                 elem_valid,
  input  logic                 elem_ready,
  output logic [WIDTH-1:0]     elem_data,
  output logic [2:0]           elem_row,
  output logic [2:0]           elem_col,
  output logic                 elem_last,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int unsigned NUM_ELEM = 25;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SETTLE, S_STREAM, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_buf [NUM_ELEM];
  logic [2:0]       r_rdim, r_cdim;
  logic [2:0]       r_row, r_col;
  logic [WIDTH-1:0] r_data;
  logic             r_en, r_valid, r_last, r_busy, r_done;
`ifdef MATRIX_FETCH_TIMEOUT_EN
  logic [15:0]      r_wait;
  logic             r_timeout_err;
`endif

  logic [2:0]       w_rdim, w_cdim;
  logic             w_xfer, w_wrap;
  logic [2:0]       w_nr, w_nc;
  logic [4:0]       w_nidx;
  logic [WIDTH-1:0] w_next_data;
  logic             w_next_last;

  // Dimension clamping applied to the raw request inputs
  always_comb begin
    w_rdim = row;
    if (row == 3'd0)                 w_rdim = 3'd1;
    else if (row > 3'(MAX_DIM))      w_rdim = 3'(MAX_DIM);
    w_cdim = col;
    if (col == 3'd0)                 w_cdim = 3'd1;
    else if (col > 3'(MAX_DIM))      w_cdim = 3'(MAX_DIM);
  end

  // Position and data of the element that follows the current one
  always_comb begin
    w_xfer      = r_valid && elem_ready;
    w_wrap      = (r_col == r_cdim - 3'd1);
    w_nc        = w_wrap ? 3'd0 : r_col + 3'd1;
    w_nr        = w_wrap ? r_row + 3'd1 : r_row;
    w_nidx      = 5'(w_nr) * 5'(r_cdim) + 5'(w_nc);
    w_next_data = (w_nidx < 5'(NUM_ELEM)) ? r_buf[w_nidx] : '0;
    w_next_last = (w_nr == r_rdim - 3'd1) && (w_nc == r_cdim - 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rdim  <= 3'd1;
      r_cdim  <= 3'd1;
      r_row   <= 3'd0;
      r_col   <= 3'd0;
      r_data  <= '0;
      r_en    <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < NUM_ELEM; k++) r_buf[k] <= '0;
`ifdef MATRIX_FETCH_TIMEOUT_EN
      r_wait        <= 16'd0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MATRIX_FETCH_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start && !gen_update_done) begin
            r_rdim  <= w_rdim;
            r_cdim  <= w_cdim;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_REQ;
`ifdef MATRIX_FETCH_TIMEOUT_EN
            r_wait  <= 16'd0;
`endif
          end
        end
        S_REQ: begin
          if (gen_update_done) r_state <= S_SETTLE;
`ifdef MATRIX_FETCH_TIMEOUT_EN
          else if (r_wait == 16'(TIMEOUT_CYCLES - 1)) begin
            r_en          <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else r_wait <= r_wait + 16'd1;
`endif
        end
        S_SETTLE: begin
          // Snapshot taken here regardless of gen_update_done in this cycle
          for (int k = 0; k < NUM_ELEM; k++) r_buf[k] <= gen_matrix_flat[k*WIDTH +: WIDTH];
          r_en    <= 1'b0;
          r_valid <= 1'b1;
          r_row   <= 3'd0;
          r_col   <= 3'd0;
          r_data  <= gen_matrix_flat[WIDTH-1:0];
          r_last  <= (r_rdim == 3'd1) && (r_cdim == 3'd1);
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_row  <= w_nr;
              r_col  <= w_nc;
              r_data <= w_next_data;
              r_last <= w_next_last;
            end
          end
        end
        S_DONE: begin
          r_row   <= 3'd0;
          r_col   <= 3'd0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gen_update_en = r_en;
  assign elem_valid    = r_valid;
  assign elem_data     = r_data;
  assign elem_row      = r_row;
  assign elem_col      = r_col;
  assign elem_last     = r_last;
  assign busy          = r_busy;
  assign done          = r_done;
`ifdef MATRIX_FETCH_TIMEOUT_EN
  assign timeout_err   = r_timeout_err;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule
